// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store front end:
// op encodings, FSM state encoding and default widths/depths.
package mem_pkg;

    localparam int SIZE        = 32;
    localparam int DEPTH_WORDS = 1024;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_RSP  = 2'd1,
        ST_RMW_MERGE = 2'd2
    } state_e;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte/half lane extract+extend and merge for a word-wide memory.
// Ports: word_i (memory word), data_i (store data), off_i (byte offset), op_i, ext_o, merged_o.
module byte_lane_unit
    import mem_pkg::*;
#(
    parameter int SIZE = mem_pkg::SIZE
) (
    input  logic [SIZE-1:0] word_i,
    input  logic [SIZE-1:0] data_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      op_i,
    output logic [SIZE-1:0] ext_o,
    output logic [SIZE-1:0] merged_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Little-endian lanes: byte k = bits [8k+7:8k], half selected by off[1].
    assign lane_b = word_i[{off_i, 3'b000} +: 8];
    assign lane_h = word_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        ext_o = word_i;
        case (op_i)
            OP_B:    ext_o = {{(SIZE-8){lane_b[7]}}, lane_b};
            OP_BU:   ext_o = {{(SIZE-8){1'b0}}, lane_b};
            OP_H:    ext_o = {{(SIZE-16){lane_h[15]}}, lane_h};
            OP_HU:   ext_o = {{(SIZE-16){1'b0}}, lane_h};
            default: ext_o = word_i;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        case (op_i)
            OP_B:    merged_o[{off_i, 3'b000} +: 8]     = data_i[7:0];
            OP_H:    merged_o[{off_i[1], 4'b0000} +: 16] = data_i[15:0];
            default: merged_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: fault decode, load extend, SB/SH read-modify-write.
// Ports: clk/rst, request (req,is_store,op,addr,store_data), stall/load/fault, DataMemory side.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int SIZE        = mem_pkg::SIZE,
    parameter int DEPTH_WORDS = mem_pkg::DEPTH_WORDS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            is_store,
    input  logic [2:0]      op,
    input  logic [SIZE-1:0] addr,
    input  logic [SIZE-1:0] store_data,
    output logic            stall,
    output logic            load_valid,
    output logic [SIZE-1:0] load_data,
    output logic            fault,
    output logic [SIZE-1:0] mem_address,
    output logic [SIZE-1:0] mem_writeData,
    output logic            mem_MemRead,
    output logic            mem_MemWrite,
    input  logic [SIZE-1:0] mem_readData
);

    typedef struct packed {
        logic [SIZE-1:0] addr;
        logic [2:0]      op;
        logic            is_store;
        logic [SIZE-1:0] store_data;
    } req_t;

    localparam logic [SIZE:0] LIMIT = (SIZE+1)'(4 * DEPTH_WORDS);

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    logic [SIZE-1:0] last_load_q, last_load_d;

    logic            bad;
    logic            accept;
    logic            is_sw;
    logic [SIZE-1:0] ext;
    logic [SIZE-1:0] merged;

    // Fault decode on the live request; only meaningful in IDLE.
    always_comb begin
        bad = 1'b0;
        case (op)
            OP_B:    bad = 1'b0;
            OP_H:    bad = addr[0];
            OP_W:    bad = (addr[1:0] != 2'b00);
            OP_BU:   bad = is_store;
            OP_HU:   bad = is_store | addr[0];
            default: bad = 1'b1;
        endcase
        if ({1'b0, addr} >= LIMIT) begin
            bad = 1'b1;
        end
    end

    assign is_sw  = is_store && (op == OP_W);
    assign accept = (state_q == ST_IDLE) && req && !bad;

    assign req_d = '{addr: addr, op: op, is_store: is_store,
                     store_data: store_data};

    byte_lane_unit #(
        .SIZE (SIZE)
    ) u_lanes (
        .word_i   (mem_readData),
        .data_i   (req_q.store_data),
        .off_i    (req_q.addr[1:0]),
        .op_i     (req_q.op),
        .ext_o    (ext),
        .merged_o (merged)
    );

    assign last_load_d = (state_q == ST_LOAD_RSP) ? ext : last_load_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            last_load_q <= '0;
        end else begin
            state_q     <= state_d;
            last_load_q <= last_load_d;
            if (accept) begin
                req_q <= req_d;
            end
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (accept && !is_sw) begin
                    state_d = is_store ? ST_RMW_MERGE : ST_LOAD_RSP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset overrides every strobe, including a pending RMW write.
    always_comb begin
        stall         = 1'b0;
        load_valid    = 1'b0;
        fault         = 1'b0;
        mem_MemRead   = 1'b0;
        mem_MemWrite  = 1'b0;
        load_data     = last_load_q;
        mem_address   = {2'b00, req_q.addr[SIZE-1:2]};
        mem_writeData = merged;
        case (state_q)
            ST_IDLE: begin
                mem_address   = {2'b00, addr[SIZE-1:2]};
                mem_writeData = store_data;
                if (!rst && req) begin
                    if (bad) begin
                        fault = 1'b1;
                    end else if (is_sw) begin
                        mem_MemWrite = 1'b1;
                    end else begin
                        mem_MemRead = 1'b1;
                        stall       = 1'b1;
                    end
                end
            end
            ST_LOAD_RSP: begin
                if (!rst) begin
                    load_valid = 1'b1;
                    load_data  = ext;
                end
            end
            ST_RMW_MERGE: begin
                mem_MemWrite = !rst;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide DataMemory.
// Inputs change after the falling edge; outputs are sampled 1 time unit later.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        is_store;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        fault;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [31:0] mem_readData;

    logic [31:0] mem [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    int nv = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .SIZE        (32),
        .DEPTH_WORDS (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .is_store      (is_store),
        .op            (op),
        .addr          (addr),
        .store_data    (store_data),
        .stall         (stall),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .fault         (fault),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_MemRead   (mem_MemRead),
        .mem_MemWrite  (mem_MemWrite),
        .mem_readData  (mem_readData)
    );

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        if (mem_MemRead) mem_readData <= mem[mem_address[9:0]];
        if (mem_MemWrite && mem_address < 32'd1024)
            mem[mem_address[9:0]] <= mem_writeData;
    end

    task automatic poke(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        req = 1'b0;
        bd_we = 1'b1; bd_idx = idx; bd_val = val;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic drive(input logic r, input logic st, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = r; is_store = st; op = o; addr = a; store_data = d;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        nv++; if (mem_MemRead !== 1'b0) begin nerr++; $display("FAIL rst_memread got %b exp 0", mem_MemRead); end
        nv++; if (stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got %b exp 0", stall); end
        nv++; if (fault !== 1'b0 || load_valid !== 1'b0 || mem_MemWrite !== 1'b0) begin nerr++; $display("FAIL rst_pulses got f%b v%b w%b exp 0", fault, load_valid, mem_MemWrite); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        nv++; if (load_data !== 32'h0) begin nerr++; $display("FAIL rst_load_data got %h exp 00000000", load_data); end
    endtask

    task automatic test_lw;
        poke(10'd4, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        nv++; if (mem_MemRead !== 1'b1 || stall !== 1'b1) begin nerr++; $display("FAIL lw_c0 got rd%b st%b exp rd1 st1", mem_MemRead, stall); end
        nv++; if (mem_address !== 32'd4) begin nerr++; $display("FAIL lw_c0_addr got %h exp 00000004", mem_address); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_valid !== 1'b1 || stall !== 1'b0 || mem_MemRead !== 1'b0) begin nerr++; $display("FAIL lw_c1 got v%b st%b rd%b exp v1 st0 rd0", load_valid, stall, mem_MemRead); end
        nv++; if (load_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL lw_data got %h exp deadbeef", load_data); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_valid !== 1'b0 || load_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL lw_hold got v%b %h exp v0 deadbeef", load_valid, load_data); end
    endtask

    task automatic test_load_ext;
        poke(10'd4, 32'h80112233);
        drive(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_valid !== 1'b1 || load_data !== 32'hFFFFFF80) begin nerr++; $display("FAIL lb_data got v%b %h exp v1 ffffff80", load_valid, load_data); end
        drive(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_valid !== 1'b1 || load_data !== 32'h00000080) begin nerr++; $display("FAIL lbu_data got v%b %h exp v1 00000080", load_valid, load_data); end
        drive(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_data !== 32'hFFFF8011) begin nerr++; $display("FAIL lh_hi_data got %h exp ffff8011", load_data); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_store_half;
        poke(10'd8, 32'h11223344);
        drive(1'b1, 1'b1, 3'b001, 32'h22, 32'h0000ABCD);
        nv++; if (mem_MemRead !== 1'b1 || stall !== 1'b1 || mem_MemWrite !== 1'b0) begin nerr++; $display("FAIL sh_c0 got rd%b st%b wr%b exp rd1 st1 wr0", mem_MemRead, stall, mem_MemWrite); end
        drive(1'b1, 1'b1, 3'b010, 32'h44, 32'h5555AAAA);
        nv++; if (mem_MemWrite !== 1'b1 || stall !== 1'b0 || mem_address !== 32'd8) begin nerr++; $display("FAIL sh_c1 got wr%b st%b a%h exp wr1 st0 a00000008", mem_MemWrite, stall, mem_address); end
        nv++; if (mem_writeData !== 32'hABCD3344) begin nerr++; $display("FAIL sh_wdata got %h exp abcd3344", mem_writeData); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (mem[8] !== 32'hABCD3344 || mem_MemWrite !== 1'b0) begin nerr++; $display("FAIL sh_mem got %h wr%b exp abcd3344 wr0", mem[8], mem_MemWrite); end
        drive(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_data !== 32'hFFFFABCD) begin nerr++; $display("FAIL lh_data got %h exp ffffabcd", load_data); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_faults;
        drive(1'b1, 1'b1, 3'b010, 32'h02, 32'h12345678);
        nv++; if (fault !== 1'b1 || stall !== 1'b0 || mem_MemRead !== 1'b0 || mem_MemWrite !== 1'b0) begin nerr++; $display("FAIL sw_mis got f%b st%b rd%b wr%b exp f1 0 0 0", fault, stall, mem_MemRead, mem_MemWrite); end
        drive(1'b1, 1'b0, 3'b001, 32'h05, 32'h0);
        nv++; if (fault !== 1'b1 || stall !== 1'b0 || mem_MemRead !== 1'b0) begin nerr++; $display("FAIL lh_mis got f%b st%b rd%b exp f1 0 0", fault, stall, mem_MemRead); end
        drive(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
        nv++; if (fault !== 1'b1 || mem_MemRead !== 1'b0) begin nerr++; $display("FAIL lw_range got f%b rd%b exp f1 rd0", fault, mem_MemRead); end
        drive(1'b1, 1'b0, 3'b010, 32'hFFC, 32'h0);
        nv++; if (fault !== 1'b0 || mem_MemRead !== 1'b1) begin nerr++; $display("FAIL lw_last_word got f%b rd%b exp f0 rd1", fault, mem_MemRead); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        nv++; if (fault !== 1'b1 || mem_MemRead !== 1'b0) begin nerr++; $display("FAIL op011 got f%b rd%b exp f1 rd0", fault, mem_MemRead); end
        drive(1'b1, 1'b1, 3'b100, 32'h10, 32'h0);
        nv++; if (fault !== 1'b1 || mem_MemRead !== 1'b0 || mem_MemWrite !== 1'b0) begin nerr++; $display("FAIL sbu got f%b rd%b wr%b exp f1 0 0", fault, mem_MemRead, mem_MemWrite); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (fault !== 1'b0) begin nerr++; $display("FAIL fault_pulse got %b exp 0", fault); end
    endtask

    task automatic test_rst_in_rmw;
        poke(10'd12, 32'hAABBCCDD);
        drive(1'b1, 1'b1, 3'b000, 32'h31, 32'h00000055);
        nv++; if (mem_MemRead !== 1'b1 || stall !== 1'b1) begin nerr++; $display("FAIL sb_c0 got rd%b st%b exp rd1 st1", mem_MemRead, stall); end
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (mem_MemWrite !== 1'b0 || stall !== 1'b0) begin nerr++; $display("FAIL rmw_rst got wr%b st%b exp wr0 st0", mem_MemWrite, stall); end
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        nv++; if (mem_MemRead !== 1'b1 || mem_MemWrite !== 1'b0) begin nerr++; $display("FAIL rmw_rst_idle got rd%b wr%b exp rd1 wr0", mem_MemRead, mem_MemWrite); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_data !== 32'hAABBCCDD) begin nerr++; $display("FAIL rmw_rst_mem got %h exp aabbccdd", load_data); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678);
        nv++; if (mem_MemWrite !== 1'b1 || stall !== 1'b0 || mem_writeData !== 32'h12345678 || mem_address !== 32'd16) begin nerr++; $display("FAIL b2b_sw got wr%b st%b %h a%h exp wr1 st0 12345678 a10", mem_MemWrite, stall, mem_writeData, mem_address); end
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        nv++; if (mem_MemRead !== 1'b1 || stall !== 1'b1) begin nerr++; $display("FAIL b2b_lw_c0 got rd%b st%b exp rd1 st1", mem_MemRead, stall); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_valid !== 1'b1 || load_data !== 32'h12345678) begin nerr++; $display("FAIL b2b_lw got v%b %h exp v1 12345678", load_valid, load_data); end
        drive(1'b1, 1'b1, 3'b000, 32'h41, 32'h0000009A);
        nv++; if (mem_MemRead !== 1'b1 || stall !== 1'b1) begin nerr++; $display("FAIL b2b_sb_c0 got rd%b st%b exp rd1 st1", mem_MemRead, stall); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (mem_MemWrite !== 1'b1 || mem_writeData !== 32'h12349A78) begin nerr++; $display("FAIL b2b_sb got wr%b %h exp wr1 12349a78", mem_MemWrite, mem_writeData); end
        drive(1'b1, 1'b0, 3'b101, 32'h42, 32'h0);
        nv++; if (mem_MemRead !== 1'b1 || stall !== 1'b1) begin nerr++; $display("FAIL b2b_lhu_c0 got rd%b st%b exp rd1 st1", mem_MemRead, stall); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (load_valid !== 1'b1 || load_data !== 32'h00001234) begin nerr++; $display("FAIL b2b_lhu got v%b %h exp v1 00001234", load_valid, load_data); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nv++; if (mem[16] !== 32'h12349A78) begin nerr++; $display("FAIL b2b_mem got %h exp 12349a78", mem[16]); end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; is_store = 1'b0; op = 3'b000;
        addr = '0; store_data = '0;
        test_reset;
        test_lw;
        test_load_ext;
        test_store_half;
        test_faults;
        test_rst_in_rmw;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule
